// File: rtl/player_hit_controller_pkg.sv
// Shared constants for the player hit controller and the HUD HP bar.
package player_hit_controller_pkg;

    localparam logic [1:0] GS_MENU  = 2'd0;
    localparam logic [1:0] GS_FIGHT = 2'd1;

    localparam int unsigned HP_MAX_DEF      = 20;
    localparam int unsigned DAMAGE_DEF      = 4;
    localparam int unsigned IFRAMES_DEF     = 30;
    localparam int unsigned BLINK_SHIFT_DEF = 2;
    localparam int unsigned HP_W_DEF        = 8;
    localparam int unsigned IFR_W           = 8;
    localparam int unsigned HIT_CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } fsm_e;

endpackage

// File: rtl/player_hit_controller_frame_countdown.sv
// Loadable down-counter advanced by frame ticks; last_o flags that the next tick ends the count.
module player_hit_controller_frame_countdown #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         last_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= (count_d == W'(1));
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/player_hit_controller.sv
// Bullet/heart overlap detection, per-frame damage, invincibility blink and death flag.
// Optional hit_count output is enabled by defining PLAYER_HIT_COUNT_EN.
module player_hit_controller
    import player_hit_controller_pkg::*;
#(
    parameter int unsigned HP_MAX      = HP_MAX_DEF,
    parameter int unsigned DAMAGE      = DAMAGE_DEF,
    parameter int unsigned IFRAMES     = IFRAMES_DEF,
    parameter int unsigned BLINK_SHIFT = BLINK_SHIFT_DEF,
    parameter int unsigned HP_W        = HP_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      state,
    input  logic            pixel_tick,
    input  logic            bullet_on,
    input  logic            heart_on,
    input  logic            frame_tick,
    output logic [HP_W-1:0] hp,
    output logic            hit_pulse,
    output logic            heart_visible,
    output logic            dead
`ifdef PLAYER_HIT_COUNT_EN
    ,
    output logic [HIT_CNT_W-1:0] hit_count
`endif
);

    localparam int unsigned BLINK_W = BLINK_SHIFT + 1;

    fsm_e               fsm_q;
    logic [HP_W-1:0]    hp_q;
    logic [HP_W-1:0]    hp_hit_d;
    logic [BLINK_W-1:0] blink_q;
    logic [BLINK_W-1:0] blink_d;
    logic               latch_q;
    logic               hit_q;
    logic               vis_q;
    logic               dead_q;

    logic restore_c;
    logic overlap_c;
    logic eval_c;
    logic hit_c;
    logic ifr_last;

    // Menu restore behaves exactly like reset.
    assign restore_c = reset || (state == GS_MENU);
    assign overlap_c = pixel_tick && bullet_on && heart_on && (state == GS_FIGHT);
    // An overlap on the frame_tick cycle still belongs to the frame being closed.
    assign eval_c    = latch_q || overlap_c;
    assign hit_c     = (fsm_q == ST_ALIVE) && frame_tick && eval_c && (state == GS_FIGHT);
    assign hp_hit_d  = (hp_q <= HP_W'(DAMAGE)) ? '0 : (hp_q - HP_W'(DAMAGE));
    assign blink_d   = blink_q + BLINK_W'(1);

    player_hit_controller_frame_countdown #(
        .W (IFR_W)
    ) u_iframes (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state == GS_MENU),
        .load_i     (hit_c),
        .load_val_i (IFR_W'(IFRAMES)),
        .tick_i     (frame_tick && (fsm_q == ST_INVULN)),
        .last_o     (ifr_last)
    );

    always_ff @(posedge clk) begin
        if (restore_c) begin
            fsm_q   <= ST_ALIVE;
            hp_q    <= HP_W'(HP_MAX);
            blink_q <= '0;
            latch_q <= 1'b0;
            hit_q   <= 1'b0;
            vis_q   <= 1'b1;
            dead_q  <= 1'b0;
        end else begin
            hit_q   <= 1'b0;
            latch_q <= frame_tick ? 1'b0 : eval_c;
            case (fsm_q)
                ST_ALIVE: begin
                    if (hit_c) begin
                        hp_q  <= hp_hit_d;
                        hit_q <= 1'b1;
                        if (hp_hit_d == '0) begin
                            fsm_q  <= ST_DEAD;
                            dead_q <= 1'b1;
                        end else begin
                            fsm_q   <= ST_INVULN;
                            blink_q <= '0;
                            vis_q   <= 1'b1;
                        end
                    end
                end
                ST_INVULN: begin
                    if (frame_tick) begin
                        if (ifr_last) begin
                            fsm_q   <= ST_ALIVE;
                            blink_q <= '0;
                            vis_q   <= 1'b1;
                        end else begin
                            blink_q <= blink_d;
                            vis_q   <= ~blink_d[BLINK_SHIFT];
                        end
                    end
                end
                ST_DEAD: begin
                    hp_q   <= '0;
                    dead_q <= 1'b1;
                end
                default: begin
                    fsm_q <= ST_ALIVE;
                end
            endcase
        end
    end

`ifdef PLAYER_HIT_COUNT_EN
    logic [HIT_CNT_W-1:0] hit_cnt_q;

    // Saturating count of registered hits.
    always_ff @(posedge clk) begin
        if (restore_c) begin
            hit_cnt_q <= '0;
        end else if (hit_c && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + HIT_CNT_W'(1);
        end
    end

    assign hit_count = hit_cnt_q;
`endif

    assign hp            = hp_q;
    assign hit_pulse     = hit_q;
    assign heart_visible = vis_q;
    assign dead          = dead_q;

endmodule

// File: tb/tb_player_hit_controller.sv
// Scoreboard bench for player_hit_controller: directed scenarios plus a random soak.
module tb_player_hit_controller;

    localparam int M_HP_MAX  = 20;
    localparam int M_DAMAGE  = 4;
    localparam int M_IFRAMES = 30;
    localparam int M_BSHIFT  = 2;

    typedef struct packed {
        logic [7:0] hp;
        logic       hit;
        logic       vis;
        logic       dead;
        logic [7:0] hc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state = 2'd0;
    logic       pixel_tick = 1'b0;
    logic       bullet_on = 1'b0;
    logic       heart_on = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] hp;
    logic       hit_pulse;
    logic       heart_visible;
    logic       dead;
`ifdef PLAYER_HIT_COUNT_EN
    logic [7:0] hit_count;
`endif

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];
    exp_t chk_e;

    int m_hp = M_HP_MAX;
    int m_fsm = 0;
    int m_cnt = 0;
    int m_blink = 0;
    int m_hc = 0;
    bit m_latch = 1'b0;

    player_hit_controller dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .pixel_tick    (pixel_tick),
        .bullet_on     (bullet_on),
        .heart_on      (heart_on),
        .frame_tick    (frame_tick),
        .hp            (hp),
        .hit_pulse     (hit_pulse),
        .heart_visible (heart_visible),
        .dead          (dead)
`ifdef PLAYER_HIT_COUNT_EN
        ,
        .hit_count     (hit_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Outputs registered at the posedge are compared at the following negedge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            chk_e = sb_q.pop_front();
            total++;
            if (hp !== chk_e.hp) begin
                bad++;
                $display("FAIL sb_hp t=%0t got=%0d want=%0d", $time, hp, chk_e.hp);
            end
            total++;
            if (hit_pulse !== chk_e.hit) begin
                bad++;
                $display("FAIL sb_hit_pulse t=%0t got=%b want=%b", $time, hit_pulse, chk_e.hit);
            end
            total++;
            if (heart_visible !== chk_e.vis) begin
                bad++;
                $display("FAIL sb_heart_visible t=%0t got=%b want=%b", $time, heart_visible, chk_e.vis);
            end
            total++;
            if (dead !== chk_e.dead) begin
                bad++;
                $display("FAIL sb_dead t=%0t got=%b want=%b", $time, dead, chk_e.dead);
            end
`ifdef PLAYER_HIT_COUNT_EN
            total++;
            if (hit_count !== chk_e.hc) begin
                bad++;
                $display("FAIL sb_hit_count t=%0t got=%0d want=%0d", $time, hit_count, chk_e.hc);
            end
`endif
        end
    end

    // Drive one clock of stimulus, advance the reference model and queue its prediction.
    task automatic cyc(input logic r, input logic [1:0] st, input logic pt,
                       input logic bo, input logic ho, input logic ft);
        exp_t e;
        bit   ovl;
        bit   ev;
        bit   hit;
        reset      = r;
        state      = st;
        pixel_tick = pt;
        bullet_on  = bo;
        heart_on   = ho;
        frame_tick = ft;
        ovl = pt && bo && ho && (st == 2'd1);
        hit = 1'b0;
        if (r || st == 2'd0) begin
            m_hp = M_HP_MAX; m_fsm = 0; m_latch = 1'b0;
            m_cnt = 0; m_blink = 0; m_hc = 0;
        end else begin
            ev = m_latch || ovl;
            m_latch = ft ? 1'b0 : ev;
            if (ft) begin
                if (m_fsm == 0) begin
                    if (ev && st == 2'd1) begin
                        hit = 1'b1;
                        m_hp = (m_hp <= M_DAMAGE) ? 0 : m_hp - M_DAMAGE;
                        if (m_hc < 255) m_hc++;
                        if (m_hp == 0) m_fsm = 2;
                        else begin m_fsm = 1; m_cnt = M_IFRAMES; m_blink = 0; end
                    end
                end else if (m_fsm == 1) begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_fsm = 0; m_blink = 0; end
                    else m_blink++;
                end
            end
        end
        e.hp   = 8'(m_hp);
        e.hit  = hit;
        e.vis  = (m_fsm == 1) ? (((m_blink >> M_BSHIFT) & 1) == 0) : 1'b1;
        e.dead = (m_fsm == 2);
        e.hc   = 8'(m_hc);
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    // Eight pixel cycles (bullet on at ovl_pix, -1 for none) followed by a frame_tick cycle.
    task automatic frame(input logic [1:0] st, input int ovl_pix, input bit ovl_tick);
        for (int i = 0; i < 8; i++) cyc(1'b0, st, 1'b1, (i == ovl_pix), 1'b1, 1'b0);
        cyc(1'b0, st, 1'b1, ovl_tick, 1'b1, 1'b1);
    endtask

    task automatic test_reset;
        cyc(1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (hp !== 8'd20 || dead !== 1'b0 || heart_visible !== 1'b1 || hit_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got hp=%0d dead=%b vis=%b hit=%b want hp=20 dead=0 vis=1 hit=0",
                     hp, dead, heart_visible, hit_pulse);
        end
    endtask

    task automatic test_single_hit;
        frame(2'd1, 3, 1'b0);
        total++;
        if (hp !== 8'd16 || hit_pulse !== 1'b1) begin
            bad++;
            $display("FAIL single_hit got hp=%0d hit=%b want hp=16 hit=1", hp, hit_pulse);
        end
        cyc(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (hit_pulse !== 1'b0) begin
            bad++;
            $display("FAIL hit_pulse_width got=%b want=0", hit_pulse);
        end
        for (int f = 0; f < 3; f++) frame(2'd1, -1, 1'b0);
        total++;
        if (heart_visible !== 1'b1) begin
            bad++;
            $display("FAIL blink_frame3 got=%b want=1", heart_visible);
        end
        frame(2'd1, -1, 1'b0);
        total++;
        if (heart_visible !== 1'b0) begin
            bad++;
            $display("FAIL blink_frame4 got=%b want=0", heart_visible);
        end
    endtask

    task automatic test_invuln;
        for (int f = 0; f < 25; f++) frame(2'd1, f % 8, 1'b1);
        total++;
        if (hp !== 8'd16 || dead !== 1'b0) begin
            bad++;
            $display("FAIL invuln_ignore got hp=%0d dead=%b want hp=16 dead=0", hp, dead);
        end
        frame(2'd1, 2, 1'b0);
        total++;
        if (hp !== 8'd16 || heart_visible !== 1'b1) begin
            bad++;
            $display("FAIL invuln_exit got hp=%0d vis=%b want hp=16 vis=1", hp, heart_visible);
        end
        frame(2'd1, 5, 1'b0);
        total++;
        if (hp !== 8'd12) begin
            bad++;
            $display("FAIL post_invuln_hit got=%0d want=12", hp);
        end
    endtask

    task automatic test_death;
        logic [7:0] want;
        want = 8'd12;
        for (int h = 0; h < 3; h++) begin
            for (int f = 0; f < 30; f++) frame(2'd1, -1, 1'b0);
            frame(2'd1, 1, 1'b0);
            want = want - 8'd4;
            total++;
            if (hp !== want) begin
                bad++;
                $display("FAIL death_hit%0d got=%0d want=%0d", h, hp, want);
            end
        end
        total++;
        if (dead !== 1'b1) begin
            bad++;
            $display("FAIL dead_flag got=%b want=1", dead);
        end
        for (int f = 0; f < 3; f++) frame(2'd1, f, 1'b1);
        total++;
        if (hp !== 8'd0 || hit_pulse !== 1'b0 || dead !== 1'b1) begin
            bad++;
            $display("FAIL dead_hold got hp=%0d hit=%b dead=%b want hp=0 hit=0 dead=1", hp, hit_pulse, dead);
        end
    endtask

    task automatic test_menu_restore;
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (hp !== 8'd20 || dead !== 1'b0 || heart_visible !== 1'b1) begin
            bad++;
            $display("FAIL menu_restore got hp=%0d dead=%b vis=%b want hp=20 dead=0 vis=1", hp, dead, heart_visible);
        end
    endtask

    task automatic test_tick_overlap;
        frame(2'd1, -1, 1'b1);
        total++;
        if (hp !== 8'd16 || hit_pulse !== 1'b1) begin
            bad++;
            $display("FAIL tick_overlap got hp=%0d hit=%b want hp=16 hit=1", hp, hit_pulse);
        end
        cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_state2;
        for (int f = 0; f < 3; f++) frame(2'd2, 4, 1'b1);
        frame(2'd3, 0, 1'b1);
        frame(2'd1, -1, 1'b0);
        total++;
        if (hp !== 8'd20 || dead !== 1'b0) begin
            bad++;
            $display("FAIL state2_no_damage got hp=%0d dead=%b want hp=20 dead=0", hp, dead);
        end
    endtask

    task automatic test_reset_mid_invuln;
        frame(2'd1, 2, 1'b0);
        for (int f = 0; f < 18; f++) frame(2'd1, -1, 1'b0);
        cyc(1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (hp !== 8'd20 || dead !== 1'b0 || heart_visible !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_invuln got hp=%0d dead=%b vis=%b want hp=20 dead=0 vis=1", hp, dead, heart_visible);
        end
`ifdef PLAYER_HIT_COUNT_EN
        total++;
        if (hit_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_hit_count got=%0d want=0", hit_count);
        end
`endif
        frame(2'd1, 4, 1'b0);
        total++;
        if (hp !== 8'd16) begin
            bad++;
            $display("FAIL alive_after_reset got=%0d want=16", hp);
        end
    endtask

    task automatic test_random;
        int         r;
        logic [1:0] st;
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            st = (r < 2) ? 2'd0 : (r < 7) ? 2'd2 : (r < 12) ? 2'd3 : 2'd1;
            cyc(($urandom_range(0, 299) == 0), st,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_invuln();
        test_death();
        test_menu_restore();
        test_tick_overlap();
        test_state2();
        test_reset_mid_invuln();
        test_random();
        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
